// File: rtl/mem_arb_pkg.sv
// Shared types and address helpers for the fetch/data SRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } rsp_tag_t;

  localparam int unsigned STARVE_W = 4;

  // 33-bit arithmetic so an address just below 2^32 can never wrap into range.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned aw);
    logic [32:0] off;
    logic [32:0] size;
    off  = {1'b0, addr} - {1'b0, base};
    size = 33'd4 << aw;
    return (addr >= base) && (off < size);
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency tag pipeline; the last stage marks which port owns the SRAM read data.
module mem_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t [MEM_LATENCY-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < MEM_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the core fetch and data ports (data priority,
// fetch starvation guard, fixed-latency response routing).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MEM_AW       = 14,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  input  logic [31:0]       instr_addr_i,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                gnt_i, gnt_d, any_gnt, sel_ok;
  logic [31:0]         sel_addr;
  rsp_tag_t            tag_in, tag_out;

  // Grants are gated by reset so nothing is accepted while rst_i is high.
  always_comb begin
    gnt_d    = data_req_i && !(instr_req_i && (starve_cnt >= LIMIT)) && !rst_i;
    gnt_i    = instr_req_i && !gnt_d && !rst_i;
    any_gnt  = gnt_i || gnt_d;
    sel_addr = gnt_d ? data_addr_i : instr_addr_i;
    sel_ok   = in_range(sel_addr, BASE_ADDR, MEM_AW);
  end

  assign instr_gnt_o = gnt_i;
  assign data_gnt_o  = gnt_d;

  assign mem_req_o   = any_gnt && sel_ok;
  assign mem_we_o    = gnt_d && data_we_i;
  assign mem_be_o    = gnt_d ? data_be_i : 4'hF;
  assign mem_addr_o  = MEM_AW'(word_offset(sel_addr, BASE_ADDR));
  assign mem_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (instr_req_i && !gnt_i) begin
      if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = any_gnt;
    tag_in.owner = gnt_d ? OWNER_DATA : OWNER_INSTR;
    tag_in.err   = any_gnt && !sel_ok;
  end

  mem_rsp_pipe #(.MEM_LATENCY(MEM_LATENCY)) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Out-of-range responses return zero data; a fetch sees it as an illegal instruction.
  assign instr_rvalid_o = tag_out.valid && (tag_out.owner == OWNER_INSTR);
  assign data_rvalid_o  = tag_out.valid && (tag_out.owner == OWNER_DATA);
  assign data_err_o     = data_rvalid_o && tag_out.err;
  assign instr_rdata_o  = tag_out.err ? 32'h0 : mem_rdata_i;
  assign data_rdata_o   = tag_out.err ? 32'h0 : mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          AW    = 14;
  localparam int          LAT   = 3;
  localparam int          SL    = 4;
  localparam int          WORDS = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0]   instr_addr_i, instr_rdata_o;
  logic          data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.BASE_ADDR(BASE), .MEM_AW(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM with LAT-cycle read latency.
  logic [31:0] sram [0:WORDS-1];
  logic [31:0] rd_pipe [0:LAT-1];
  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    rd_pipe[0] <= mem_req_o ? sram[mem_addr_o] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model state
  typedef struct {int due; bit is_data; bit err; bit chk; logic [31:0] data;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:WORDS-1];
  int          starve_m = 0;
  bit          e_gnt_i, e_gnt_d, e_mreq, e_rv_i, e_rv_d, e_err, e_chk;
  logic [AW-1:0] e_maddr;
  logic [31:0] e_data;
  int          n_cmp = 0, n_fail = 0;

  function automatic longint offset_of(input logic [31:0] a);
    return longint'({32'h0, a}) - longint'({32'h0, BASE});
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = offset_of(a);
    return (off >= 0) && (off < (longint'(4) << AW));
  endfunction

  // Expected behaviour of the current cycle, from the arbitration rules.
  task automatic model_step();
    exp_t r;
    logic [31:0] a;
    bit inr;
    int wa;
    e_rv_i = 0; e_rv_d = 0; e_err = 0; e_chk = 0; e_data = '0;
    e_gnt_i = 0; e_gnt_d = 0; e_mreq = 0; e_maddr = '0;
    if (rst_i) begin
      exp_q.delete();
      starve_m = 0;
      return;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      e_rv_i = !r.is_data; e_rv_d = r.is_data; e_err = r.err; e_chk = r.chk; e_data = r.data;
    end
    e_gnt_d = data_req_i && !(instr_req_i && starve_m >= SL);
    e_gnt_i = instr_req_i && !e_gnt_d;
    a   = e_gnt_d ? data_addr_i : instr_addr_i;
    inr = in_rng(a);
    wa  = inr ? int'(offset_of(a) / 4) : 0;
    e_mreq  = (e_gnt_i || e_gnt_d) && inr;
    e_maddr = wa[AW-1:0];
    if (e_gnt_i || e_gnt_d) begin
      r.due = cyc + LAT; r.is_data = e_gnt_d; r.err = e_gnt_d && !inr;
      r.chk = !(e_gnt_d && data_we_i && inr);
      r.data = inr ? ref_mem[wa] : 32'h0;
      exp_q.push_back(r);
      if (e_gnt_d && data_we_i && inr)
        for (int b = 0; b < 4; b++)
          if (data_be_i[b]) ref_mem[wa][8*b +: 8] = data_wdata_i[8*b +: 8];
    end
    if (instr_req_i && !e_gnt_i) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
    else starve_m = 0;
  endtask

  // Drive one cycle shortly after the edge, then sample at the falling edge.
  task automatic drive_cycle(input bit rst, input bit ir, input logic [31:0] ia,
                             input bit dr, input bit dw, input logic [3:0] dbe,
                             input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk_i); #1;
    rst_i = rst; instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dw; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
    @(negedge clk_i);
    model_step();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1, 1, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
      n_cmp++;
      if ({instr_gnt_o, data_gnt_o, mem_req_o} !== 3'b000) begin
        n_fail++; $display("FAIL reset_gnt: got %b want 000", {instr_gnt_o, data_gnt_o, mem_req_o});
      end
      n_cmp++;
      if ({instr_rvalid_o, data_rvalid_o, data_err_o} !== 3'b000) begin
        n_fail++; $display("FAIL reset_rsp: got %b want 000", {instr_rvalid_o, data_rvalid_o, data_err_o});
      end
    end
    drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_data_read();
    drive_cycle(0, 0, 32'h0, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    n_cmp++;
    if ({data_gnt_o, instr_gnt_o, mem_req_o, mem_we_o} !== 4'b1010 || mem_addr_o !== 14'd4) begin
      n_fail++; $display("FAIL rd_issue: gnt/req/we %b addr %0d want 1010 addr 4",
                         {data_gnt_o, instr_gnt_o, mem_req_o, mem_we_o}, mem_addr_o);
    end
    for (int k = 0; k < LAT; k++) begin
      drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      n_cmp++;
      if (data_rvalid_o !== (k == LAT - 1)) begin
        n_fail++; $display("FAIL rd_rvalid k=%0d: got %b want %b", k, data_rvalid_o, k == LAT - 1);
      end
      if (k == LAT - 1) begin
        n_cmp++;
        if (data_rdata_o !== ref_mem[4] || data_err_o !== 1'b0) begin
          n_fail++; $display("FAIL rd_data: got %h err %b want %h err 0", data_rdata_o, data_err_o, ref_mem[4]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [9:0] pat;
    int n_i, n_d;
    pat = 10'b1111011110;
    n_i = 0; n_d = 0;
    drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    for (int t = 0; t < 10 + LAT; t++) begin
      if (t < 10) drive_cycle(0, 1, 32'(4*t), 1, 0, 4'hF, 32'(32'h100 + 4*t), 32'h0);
      else        drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (t < 10) begin
        n_cmp++;
        if (data_gnt_o !== pat[9-t] || instr_gnt_o !== !pat[9-t] ||
            mem_addr_o !== (pat[9-t] ? 14'(16'h40 + t) : 14'(t))) begin
          n_fail++; $display("FAIL starve_gnt t=%0d: d=%b i=%b addr %0d want d=%b", t,
                             data_gnt_o, instr_gnt_o, mem_addr_o, pat[9-t]);
        end
      end
      n_cmp++;
      if ({instr_rvalid_o, data_rvalid_o} !== {e_rv_i, e_rv_d} ||
          (e_rv_i && instr_rdata_o !== e_data) || (e_rv_d && data_rdata_o !== e_data)) begin
        n_fail++; $display("FAIL starve_rsp t=%0d: rv %b%b want %b%b", t, instr_rvalid_o,
                           data_rvalid_o, e_rv_i, e_rv_d);
      end
      n_i += int'(instr_rvalid_o === 1'b1);
      n_d += int'(data_rvalid_o === 1'b1);
    end
    n_cmp++;
    if (n_i != 2 || n_d != 8) begin
      n_fail++; $display("FAIL starve_count: instr %0d data %0d want 2 8", n_i, n_d);
    end
  endtask

  task automatic test_out_of_range();
    for (int t = 0; t < LAT + 2; t++) begin
      if (t == 0)      drive_cycle(0, 0, 32'h0, 1, 1, 4'hF, 32'h0001_0000, 32'h1234_5678);
      else if (t == 1) drive_cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 4'h0, 32'h0, 32'h0);
      else             drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (t < 2) begin
        n_cmp++;
        if ((t == 0 ? data_gnt_o : instr_gnt_o) !== 1'b1 || mem_req_o !== 1'b0) begin
          n_fail++; $display("FAIL oob_issue t=%0d: gnt d%b i%b mem_req %b want gnt 1 req 0",
                             t, data_gnt_o, instr_gnt_o, mem_req_o);
        end
      end
      if (t == LAT) begin
        n_cmp++;
        if ({data_rvalid_o, data_err_o, instr_rvalid_o} !== 3'b110 || data_rdata_o !== 32'h0) begin
          n_fail++; $display("FAIL oob_data_rsp: rv/err/irv %b rdata %h want 110 0",
                             {data_rvalid_o, data_err_o, instr_rvalid_o}, data_rdata_o);
        end
      end
      if (t == LAT + 1) begin
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'h0) begin
          n_fail++; $display("FAIL oob_fetch_rsp: rv %b%b rdata %h want 10 0",
                             instr_rvalid_o, data_rvalid_o, instr_rdata_o);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < LAT + 4; t++) begin
      if (t < 3) drive_cycle(0, 1, 32'(4*t), 0, 0, 4'h0, 32'h0, 32'h0);
      else       drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (t < 3) begin
        n_cmp++;
        if (instr_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 14'(t) ||
            mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
          n_fail++; $display("FAIL b2b_issue t=%0d: gnt %b req %b addr %0d we %b be %h want 1 1 %0d 0 f",
                             t, instr_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, t);
        end
      end
      n_cmp++;
      if (instr_rvalid_o !== (t >= LAT && t < LAT + 3) || (e_rv_i && instr_rdata_o !== e_data)) begin
        n_fail++; $display("FAIL b2b_rsp t=%0d: rv %b rdata %h want rv %b rdata %h", t,
                           instr_rvalid_o, instr_rdata_o, t >= LAT && t < LAT + 3, e_data);
      end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] old, want;
    old  = ref_mem[8];
    want = {old[31:16], 8'hCC, old[7:0]};
    for (int t = 0; t < LAT + 2; t++) begin
      if (t == 0)      drive_cycle(0, 0, 32'h0, 1, 1, 4'b0010, 32'h20, 32'hAABBCCDD);
      else if (t == 1) drive_cycle(0, 0, 32'h0, 1, 0, 4'hF, 32'h23, 32'h0);
      else             drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (t == 0) begin
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0010 ||
            mem_addr_o !== 14'd8 || mem_wdata_o !== 32'hAABBCCDD) begin
          n_fail++; $display("FAIL bw_issue: req %b we %b be %b addr %0d wdata %h want 1 1 0010 8 aabbccdd",
                             mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
      end
      if (t >= LAT) begin
        n_cmp++;
        if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0 ||
            (t == LAT + 1 && data_rdata_o !== want)) begin
          n_fail++; $display("FAIL bw_rsp t=%0d: rv %b err %b rdata %h want 1 0 %h", t,
                             data_rvalid_o, data_err_o, data_rdata_o, want);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int t = 0; t < 4; t++) drive_cycle(0, 1, 32'h40, 1, 0, 4'hF, 32'(32'h30 + 4*t), 32'h0);
    for (int t = 4; t < 6 + LAT; t++) begin
      if (t == 4)      drive_cycle(1, 1, 32'h40, 1, 0, 4'hF, 32'h50, 32'h0);
      else if (t == 5) drive_cycle(0, 1, 32'h40, 1, 0, 4'hF, 32'h54, 32'h0);
      else             drive_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      if (t == 5) begin
        n_cmp++;
        if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0) begin
          n_fail++; $display("FAIL rst_first_gnt: d %b i %b want 1 0", data_gnt_o, instr_gnt_o);
        end
      end
      n_cmp++;
      if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== (t == 5 + LAT)) begin
        n_fail++; $display("FAIL rst_flush t=%0d: rv %b%b want 0%b", t, instr_rvalid_o,
                           data_rvalid_o, t == 5 + LAT);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] oob [4];
    logic [31:0] ia, da;
    bit rst;
    oob[0] = 32'h0001_0000; oob[1] = 32'hFFFF_FFFC; oob[2] = 32'h8000_0002; oob[3] = 32'h0000_FFFD;
    for (int t = 0; t < n; t++) begin
      ia  = ($urandom_range(0, 7) == 0) ? oob[$urandom_range(0, 3)] : 32'($urandom_range(0, 255));
      da  = ($urandom_range(0, 7) == 0) ? oob[$urandom_range(0, 3)] : 32'($urandom_range(0, 255));
      rst = ($urandom_range(0, 63) == 0);
      drive_cycle(rst, 1'($urandom), ia, 1'($urandom), 1'($urandom), 4'($urandom), da, $urandom);
      n_cmp++;
      if ({instr_gnt_o, data_gnt_o, mem_req_o} !== {e_gnt_i, e_gnt_d, e_mreq} ||
          (e_mreq && mem_addr_o !== e_maddr)) begin
        n_fail++; $display("FAIL rnd_issue t=%0d: gnt/req %b addr %0d want %b addr %0d", t,
                           {instr_gnt_o, data_gnt_o, mem_req_o}, mem_addr_o,
                           {e_gnt_i, e_gnt_d, e_mreq}, e_maddr);
      end
      if (e_mreq && e_gnt_d) begin
        n_cmp++;
        if (mem_we_o !== data_we_i || mem_be_o !== data_be_i || (data_we_i && mem_wdata_o !== data_wdata_i)) begin
          n_fail++; $display("FAIL rnd_wr t=%0d: we %b be %h wdata %h want %b %h %h", t, mem_we_o,
                             mem_be_o, mem_wdata_o, data_we_i, data_be_i, data_wdata_i);
        end
      end
      n_cmp++;
      if ({instr_rvalid_o, data_rvalid_o} !== {e_rv_i, e_rv_d} ||
          (e_rv_d && data_err_o !== e_err) ||
          (e_rv_d && e_chk && data_rdata_o !== e_data) ||
          (e_rv_i && instr_rdata_o !== e_data)) begin
        n_fail++; $display("FAIL rnd_rsp t=%0d: rv %b%b err %b id %h dd %h want %b%b err %b data %h", t,
                           instr_rvalid_o, data_rvalid_o, data_err_o, instr_rdata_o, data_rdata_o,
                           e_rv_i, e_rv_d, e_err, e_data);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0; data_we_i = 1'b0;
    data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_data_read();
    test_starvation();
    test_out_of_range();
    test_back_to_back();
    test_byte_write();
    test_reset_midflight();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the RISC-V core instruction-fetch port and its data port.
- Both core ports use the req/gnt/rvalid protocol.
- Arbitration is data-priority with a starvation guard for fetch.
- A fixed-latency response pipeline routes read data, write acknowledges and out-of-range errors back to the granted port.
- Sits between the core and the boot/program RAM, in place of two separate memories.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0.
- MEM_AW, 14, SRAM word-address width; memory size is 4*2^MEM_AW bytes.
- MEM_LATENCY, 1, cycles from mem_req_o to valid mem_rdata_i (1..4).
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles before fetch wins priority (1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch byte address
- instr_rdata_o  out  32  fetch data
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- data_err_o  out  1  error, qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data

Behaviour:
- Clock is clk_i; reset is rst_i, asynchronous, active-high.
- Reset values:
  - All registered outputs are 0.
  - Response pipeline is cleared and starvation counter = 0.
  - instr_gnt_o, data_gnt_o and mem_req_o are forced 0 while rst_i = 1.
- Grant timing:
  - Grant is combinational, in the same cycle as req.
  - At most one grant per cycle.
  - A new grant is allowed every cycle (full throughput).
- Arbitration:
  - Only data requesting -> data granted.
  - Only instr requesting -> instr granted.
  - Both requesting -> data granted, unless starve_cnt >= STARVE_LIMIT, in which case instr is granted.
- starve_cnt, 4-bit, saturating:
  - Increments each cycle instr_req_i = 1 and instr is not granted.
  - Clears on an instr grant or when instr_req_i = 0.
- Range check: in_range = (addr >= BASE_ADDR) && (addr - BASE_ADDR < 4*2^MEM_AW), 33-bit compare so there is no wrap at 2^32.
  - Word address = (addr - BASE_ADDR)[MEM_AW+1:2].
  - addr[1:0] are ignored.
- Granted and in range:
  - mem_req_o = 1 with that port's address.
  - Instr side drives we = 0, be = 4'hF.
  - Data side drives we, be and wdata.
- Granted and out of range:
  - The port is still granted; mem_req_o = 0.
  - The response carries err = 1.
- Response pipeline: MEM_LATENCY stages of {valid, owner, err}.
  - Stage 0 is loaded on any grant; it shifts every cycle (no stall, the core always accepts rvalid).
  - At the last stage, rvalid goes to the owner port.
  - rdata = mem_rdata_i, or 32'h0 if err.
  - data_err_o = err for data responses.
  - A fetch error returns rdata 0 (decodes as illegal instruction); there is no err line on the fetch port.
- Writes also produce rvalid after MEM_LATENCY cycles; rdata is don't-care, driven as mem_rdata_i.
- rvalid for both ports can never be asserted in the same cycle, since there is one grant per cycle.
- Response ordering equals grant ordering per port and globally.
- rst_i asserted mid-operation: in-flight responses are discarded; no rvalid appears after reset release.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_e
  - typedef struct packed {logic valid; owner_e owner; logic err;} rsp_tag_t
  - function in_range(addr, base, aw)
- Sub-module mem_rsp_pipe:
  - Parameterised MEM_LATENCY shift register of rsp_tag_t.
  - Async active-high reset.
  - Outputs the last stage.

Test Plan:
- Data read at 0x0000_0010, MEM_LATENCY = 1 -> same-cycle data_gnt_o, mem_addr_o = 4; next cycle data_rvalid_o = 1, data_rdata_o = mem_rdata_i, data_err_o = 0.
- instr_req_i and data_req_i held high 10 cycles, STARVE_LIMIT = 4 -> grant pattern D,D,D,D,I,D,D,D,D,I; every grant yields exactly one rvalid to the correct port, in order.
- Data write to 0x0001_0000 with MEM_AW = 14 (out of range) -> data_gnt_o = 1, mem_req_o = 0, one cycle later data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- MEM_LATENCY = 3, back-to-back fetches at 0x0, 0x4, 0x8 -> mem_addr_o = 0, 1, 2 on consecutive cycles; instr_rvalid_o high for 3 cycles starting 3 cycles after the first grant.
- Byte write be = 4'b0010, wdata = 32'hAABBCCDD at 0x20 -> mem_we_o = 1, mem_be_o = 4'b0010, mem_addr_o = 8, mem_wdata_o = 32'hAABBCCDD; data_rvalid_o follows after MEM_LATENCY.
- rst_i pulsed one cycle after a read grant, MEM_LATENCY = 2 -> no rvalid on either port afterwards; starve_cnt = 0, and the first post-reset dual request grants data.
